// File: rtl/mux_stream_if.sv
// mux_stream handshake bundle: N input channels in, one registered stream out.
// out_par exists only when MUX_STREAM_PARITY_EN is defined.
interface mux_stream_if #(
  parameter int W  = 8,
  parameter int N  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_ch;
`ifdef MUX_STREAM_PARITY_EN
  logic           out_par;
`endif

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
`ifdef MUX_STREAM_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
`ifdef MUX_STREAM_PARITY_EN
    , input out_par
`endif
  );
endinterface

// File: rtl/mux_stream.sv
// N-to-1 stream mux, fixed or round-robin select, single output register.
// Optional out_par (even parity of out_data) under MUX_STREAM_PARITY_EN.
module mux_stream #(
  parameter int W  = 8,
  parameter int N  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input logic         clk,
  input logic         rst,
  mux_stream_if.slave bus
);

  logic [W-1:0]  r_data;
  logic [SW-1:0] r_ch;
  logic [SW-1:0] r_ptr;
  logic          r_valid;
`ifdef MUX_STREAM_PARITY_EN
  logic          r_par;
`endif

  logic          w_ld;
  logic          w_gnt;
  logic [SW-1:0] w_gidx;
  logic [W-1:0]  w_word;
  logic [N-1:0]  w_rdy;

  assign w_ld = !r_valid || bus.out_ready;

  // Search order for round-robin starts just after the last grant.
  always_comb begin
    int idx;
    w_gnt  = 1'b0;
    w_gidx = '0;
    idx    = 0;
    if (rst && w_ld) begin
      if (!bus.mode) begin
        for (int i = 0; i < N; i++) begin
          if (i == int'(bus.sel) && bus.in_valid[i]) begin
            w_gnt  = 1'b1;
            w_gidx = SW'(i);
          end
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          idx = (int'(r_ptr) + k) % N;
          if (!w_gnt && bus.in_valid[idx]) begin
            w_gnt  = 1'b1;
            w_gidx = SW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    w_word = '0;
    w_rdy  = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_gidx) == i) begin
        w_word   = bus.in_data[i*W +: W];
        w_rdy[i] = w_gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= SW'(N - 1);
`ifdef MUX_STREAM_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_gnt) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
      r_ch    <= w_gidx;
      if (bus.mode)
        r_ptr <= w_gidx;
`ifdef MUX_STREAM_PARITY_EN
      r_par   <= ^w_word;
`endif
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_rdy;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_ch    = r_ch;
`ifdef MUX_STREAM_PARITY_EN
  assign bus.out_par   = r_par;
`endif

endmodule

// File: tb/tb_mux_stream.sv
// Self-checking bench for mux_stream: directed cases plus random traffic
// against a reference model with a transfer scoreboard.
module tb_mux_stream;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_stream_if #(.W(W), .N(N)) bus ();
  mux_stream #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  mux_stream_if #(.W(W), .N(3)) bus3 ();
  mux_stream #(.W(W), .N(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit       m_valid = 1'b0;
  bit [7:0] m_data  = '0;
  int       m_ch    = 0;
  int       m_ptr   = N - 1;
  bit [7:0] m_q[$];
  int       n_push  = 0;
  int       n_pop   = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Grant rules from the behavioural description.
  function automatic int pick();
    bit ld;
    ld = !m_valid || bus.out_ready;
    if (!rst || !ld) return -1;
    if (!bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel])
        return int'(bus.sel);
      return -1;
    end
    for (int k = 1; k <= N; k++)
      if (bus.in_valid[(m_ptr + k) % N])
        return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    bit [7:0] w;
    bit [7:0] f;
    #1;
    g = pick();
    chk("in_ready", bus.in_ready,
        (g >= 0) ? (64'd1 << g) : 64'd0);
    if (rst && m_valid && bus.out_ready) begin
      if (m_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        f = m_q.pop_front();
        n_pop++;
        chk("sb_data", bus.out_data, f);
      end
    end
    w = (g >= 0) ? bus.in_data[g*W +: W] : 8'h0;
    @(posedge clk);
    if (!rst) begin
      m_valid = 0; m_data = 0; m_ch = 0;
      m_ptr = N - 1; m_q.delete();
    end else if (g >= 0) begin
      m_valid = 1; m_data = w; m_ch = g;
      if (bus.mode) m_ptr = g;
      m_q.push_back(w);
      n_push++;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_data", bus.out_data, m_data);
    chk("out_ch", bus.out_ch, m_ch);
`ifdef MUX_STREAM_PARITY_EN
    chk("out_par", bus.out_par, ^m_data);
`endif
  endtask

  initial begin
    bus.in_data = '0; bus.in_valid = '0;
    bus.sel = '0; bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    bus3.in_data = '0; bus3.in_valid = '0;
    bus3.sel = '0; bus3.mode = 1'b0;
    bus3.out_ready = 1'b1;

    // Reset
    rst = 1'b0;
    cycle(); cycle();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ch", bus.out_ch, 0);

    // Fixed select of channel 2
    rst = 1'b1;
    bus.mode = 1'b0; bus.sel = 2'd2;
    bus.in_valid = 4'b0100;
    bus.in_data = 32'h00A5_0000;
    bus.out_ready = 1'b1;
    #1;
    chk("fix_rdy", bus.in_ready, 4'b0100);
    cycle();
    chk("fix_data", bus.out_data, 8'hA5);
    chk("fix_ch", bus.out_ch, 2);
    chk("fix_valid", bus.out_valid, 1);

    // Round-robin across four busy channels
    rst = 1'b0; bus.in_valid = '0;
    cycle();
    rst = 1'b1; bus.mode = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = $urandom;
      cycle();
      chk("rr_ch", bus.out_ch, i % 4);
    end

    // Back-pressure holds the word
    bus.mode = 1'b0; bus.sel = 2'd1;
    bus.in_valid = 4'b0010;
    bus.in_data = 32'h0000_3C00;
    cycle();
    chk("bp_load", bus.out_data, 8'h3C);
    bus.out_ready = 1'b0;
    bus.in_data = 32'h0000_9900;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold", bus.out_data, 8'h3C);
      chk("bp_rdy", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_data = 32'h0000_5500;
    cycle();
    chk("bp_next", bus.out_data, 8'h55);
    bus.in_valid = '0;
    cycle();
    chk("bp_drain", bus.out_valid, 0);

    // Sparse round-robin with wrap
    rst = 1'b0;
    cycle();
    rst = 1'b1; bus.mode = 1'b1;
    bus.in_valid = 4'b0010;
    cycle();
    chk("sp_ch1", bus.out_ch, 1);
    bus.in_valid = 4'b1001;
    cycle();
    chk("sp_ch3", bus.out_ch, 3);
    cycle();
    chk("sp_ch0", bus.out_ch, 0);

    // Out-of-range select on the 3-channel build
    bus.in_valid = '0;
    bus3.sel = 2'd3; bus3.in_valid = 3'b111;
    bus3.in_data = 24'h112233;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("n3_rdy", bus3.in_ready, 0);
      chk("n3_valid", bus3.out_valid, 0);
    end
    bus3.in_valid = '0;

    // Reset while a word is held
    bus.mode = 1'b0; bus.sel = 2'd0;
    bus.in_valid = 4'b0001;
    bus.in_data = 32'h0000_0077;
    bus.out_ready = 1'b0;
    cycle();
    chk("mr_load", bus.out_data, 8'h77);
    bus.in_valid = '0;
    cycle();
    rst = 1'b0;
    bus.in_valid = 4'b1111;
    #1;
    chk("mr_rdy", bus.in_ready, 0);
    cycle();
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_data", bus.out_data, 0);
`ifdef MUX_STREAM_PARITY_EN
    chk("mr_par", bus.out_par, 0);
`endif
    rst = 1'b1; bus.mode = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = $urandom;
    cycle();
    chk("mr_rr0", bus.out_ch, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      bus.mode = 1'($urandom);
      bus.sel = 2'($urandom);
      bus.in_valid = 4'($urandom);
      bus.in_data = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain and account for every accepted word
    rst = 1'b1;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    cycle(); cycle();
    chk("sb_empty", m_q.size(), 0);
    chk("sb_count", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
